// File: rtl/config_chain_loader_pkg.sv
// Shared types and helpers for the configuration chain loader.
package config_chain_loader_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StShift,
    StDrain
  } state_e;

  // Counter width able to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/config_readback_packer.sv
// Serial-to-word packer for bits returned from the chain tail. Collects one bit per
// accepted capture, presents completed words on a valid/ready port and raises stall
// when the next capture would overwrite a word the consumer has not yet taken.
module config_readback_packer
  import config_chain_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  last_bit,
  output logic                  stall,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready
);

  localparam int unsigned RbW = cnt_width(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] rb_sr_q, rb_sr_d;
  logic [RbW-1:0]        rb_cnt_q, rb_cnt_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [WORD_WIDTH-1:0] merged;
  logic                  word_full;

  // The next capture closes a word, either by filling it or by taking the final chain bit.
  assign word_full = (rb_cnt_q == RbW'(WORD_WIDTH - 1)) || last_bit;
  assign stall     = rd_valid_q && !rd_ready && word_full;

  // rb_sr is kept zero above rb_cnt, so OR-ing in the new bit is enough and leaves
  // unused upper bits of a partial word at 0.
  assign merged = rb_sr_q | (WORD_WIDTH'(bit_in) << rb_cnt_q);

  // Next-state for capture register, bit counter and output word.
  always_comb begin
    rb_sr_d    = rb_sr_q;
    rb_cnt_d   = rb_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end

    if (clear) begin
      rb_sr_d  = '0;
      rb_cnt_d = '0;
    end else if (bit_valid) begin
      if (word_full) begin
        // A completed word replaces the one just handed off in the same cycle.
        rd_data_d  = merged;
        rd_valid_d = 1'b1;
        rb_sr_d    = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_sr_d  = merged;
        rb_cnt_d = rb_cnt_q + RbW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_sr_q    <= '0;
      rb_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rb_sr_q    <= rb_sr_d;
      rb_cnt_q   <= rb_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/config_chain_loader.sv
// Host-side driver for the serial configuration chain. Takes words on a valid/ready
// port, shifts them LSB first into the chain head with one shift strobe per bit, and
// packs the bits leaving the chain tail into readback words.
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = 64,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic                  Config_Clock,
  input  logic                  Config_Reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  config_out,
  output logic                  config_shift_en,
  input  logic                  config_return,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready
);

  localparam int unsigned CNT_WIDTH = cnt_width(CHAIN_LENGTH);
  localparam int unsigned WCW       = cnt_width(WORD_WIDTH);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [CNT_WIDTH-1:0]  bits_left_q, bits_left_d;
  logic [WCW-1:0]        word_left_q, word_left_d;
  logic                  done_q, done_d;
  logic                  last_bit;
  logic                  stall;
  logic                  rb_clear;

  assign last_bit = (bits_left_q == CNT_WIDTH'(1));

  // Readback capture runs off the same shift strobe the chain sees.
  config_readback_packer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_packer (
    .clk       (Config_Clock),
    .rst       (Config_Reset),
    .clear     (rb_clear),
    .bit_valid (config_shift_en),
    .bit_in    (config_return),
    .last_bit  (last_bit),
    .stall     (stall),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready)
  );

  // Next-state and output decode for the transmit FSM.
  always_comb begin
    state_d         = state_q;
    tx_sr_d         = tx_sr_q;
    bits_left_d     = bits_left_q;
    word_left_d     = word_left_q;
    done_d          = 1'b0;
    cfg_ready       = 1'b0;
    config_out      = 1'b0;
    config_shift_en = 1'b0;
    rb_clear        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFetch;
          bits_left_d = CNT_WIDTH'(CHAIN_LENGTH);
          rb_clear    = 1'b1;
        end
      end

      StFetch: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          tx_sr_d = cfg_data;
          // Final word may be partial; its bits above word_left are never shifted.
          if (32'(bits_left_q) >= WORD_WIDTH) begin
            word_left_d = WCW'(WORD_WIDTH);
          end else begin
            word_left_d = WCW'(bits_left_q);
          end
          state_d = StShift;
        end
      end

      StShift: begin
        config_out      = tx_sr_q[0];
        config_shift_en = !stall;
        if (!stall) begin
          tx_sr_d     = tx_sr_q >> 1;
          bits_left_d = bits_left_q - CNT_WIDTH'(1);
          word_left_d = word_left_q - WCW'(1);
          if (last_bit) begin
            state_d = StDrain;
          end else if (word_left_q == WCW'(1)) begin
            state_d = StFetch;
          end
        end
      end

      StDrain: begin
        // Finish once the last readback word has been taken.
        if (!rd_valid || rd_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any load in progress.
  always_ff @(posedge Config_Clock) begin
    if (Config_Reset) begin
      state_q     <= StIdle;
      tx_sr_q     <= '0;
      bits_left_q <= '0;
      word_left_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      bits_left_q <= bits_left_d;
      word_left_q <= word_left_d;
      done_q      <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a 12-cell chain model and 8-bit words.
module tb_config_chain_loader;

  localparam int unsigned CL = 12;
  localparam int unsigned WW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          config_out;
  logic          config_shift_en;
  logic          config_return;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;

  always #5 clk = ~clk;

  config_chain_loader #(
    .CHAIN_LENGTH (CL),
    .WORD_WIDTH   (WW)
  ) dut (
    .Config_Clock    (clk),
    .Config_Reset    (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .cfg_data        (cfg_data),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .config_out      (config_out),
    .config_shift_en (config_shift_en),
    .config_return   (config_return),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready)
  );

  // Chain model: head is the top bit, tail (returned first) is bit 0.
  logic [CL-1:0] chain;
  logic          preload;
  logic [CL-1:0] preload_val;

  always @(posedge clk) begin
    if (preload) chain <= preload_val;
    else if (config_shift_en) chain <= {config_out, chain[CL-1:1]};
  end
  assign config_return = chain[0];

  // Observation of shifted bits, readback transfers, done pulses and non-shift busy cycles.
  logic          bits_q[$];
  logic [WW-1:0] rd_q[$];
  int            done_cnt = 0;
  int            idle_cnt = 0;

  always @(negedge clk) begin
    if (config_shift_en) bits_q.push_back(config_out);
    if (rd_valid && rd_ready) rd_q.push_back(rd_data);
    if (done) done_cnt++;
    if (busy && !config_shift_en) idle_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string t);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_cfg_ready"}, cfg_ready, 0);
    chk({t, "_config_out"}, config_out, 0);
    chk({t, "_shift_en"}, config_shift_en, 0);
    chk({t, "_rd_valid"}, rd_valid, 0);
    chk({t, "_rd_data"}, rd_data, 0);
  endtask

  // Present one word; called and returns just after a rising edge.
  task automatic send_word(input logic [WW-1:0] w);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = w;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = cfg_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cfg_valid = 1'b0;
    chk("cfg_accept", acc, 1);
  endtask

  // Wait until the loader asks for a word, then keep cfg_valid low for gap cycles.
  task automatic fetch_gap(input int gap);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = cfg_ready;
      n++;
    end
    chk("fetch_reached", seen, 1);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic run_load(input string t, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                          input int gap, input int hold, input logic restart,
                          input logic [CL-1:0] exp_bits, input logic [WW-1:0] e0,
                          input logic [WW-1:0] e1, input int exp_idle, input int exp_stall);
    int            s0 = bits_q.size();
    int            r0 = rd_q.size();
    int            d0 = done_cnt;
    int            i0 = idle_cnt;
    int            nd;
    int            nr;
    logic [CL-1:0] v;
    @(posedge clk);
    #1;
    start = 1'b1;
    rd_ready = (hold == 0);
    fork
      begin
        @(posedge clk);
        #1;
        start = 1'b0;
        send_word(w0);
        if (restart) begin
          @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
        if (gap > 0) fetch_gap(gap);
        send_word(w1);
      end
      begin
        if (hold > 0) begin
          nr = 0;
          do begin
            @(negedge clk);
            nr++;
          end while (!rd_valid && nr < 200);
          chk({t, "_rd_first"}, rd_valid, 1);
          repeat (hold) begin
            @(negedge clk);
            chk({t, "_hold_data"}, rd_data, e0);
            chk({t, "_hold_valid"}, rd_valid, 1);
          end
          @(posedge clk);
          chk({t, "_stalled_shifts"}, bits_q.size() - s0, exp_stall);
          #1 rd_ready = 1'b1;
        end
      end
    join
    nd = 0;
    while (done_cnt == d0 && nd < 300) begin
      @(posedge clk);
      nd++;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < CL; i++) v[i] = (bits_q.size() > s0 + i) ? bits_q[s0 + i] : 1'bx;
    chk({t, "_shifts"}, bits_q.size() - s0, CL);
    chk({t, "_bits"}, v, exp_bits);
    chk({t, "_done_pulses"}, done_cnt - d0, 1);
    chk({t, "_rd_count"}, rd_q.size() - r0, 2);
    chk({t, "_rd0"}, (rd_q.size() > r0) ? rd_q[r0] : 8'hxx, e0);
    chk({t, "_rd1"}, (rd_q.size() > r0 + 1) ? rd_q[r0 + 1] : 8'hxx, e1);
    chk({t, "_idle_cycles"}, idle_cnt - i0, exp_idle);
    chk({t, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int s0;
    int d0;
    int n;
    rst = 1'b1;
    start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = '0;
    rd_ready = 1'b1;
    preload = 1'b1;
    preload_val = 12'hF0F;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic load; chain preloaded to 0xF0F reads back 0x0F, 0x0F.
    run_load("t1", 8'hA5, 8'h03, 0, 0, 1'b0, 12'h3A5, 8'h0F, 8'h0F, 3, 0);
    // Second word held off 5 cycles; readback is the first load.
    run_load("t2", 8'h3C, 8'h0A, 5, 0, 1'b0, 12'hA3C, 8'hA5, 8'h03, 8, 0);
    // Consumer holds off 10 cycles; final bit stalls, upper bits of 0xF5 ignored.
    run_load("t3", 8'hFF, 8'hF5, 0, 10, 1'b0, 12'h5FF, 8'h3C, 8'h0A, 10, 11);

    // Reset after 5 shifts aborts the load.
    s0 = bits_q.size();
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 8'h11;
    n = 0;
    while (bits_q.size() - s0 < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("t4_pre_shifts", bits_q.size() - s0, 5);
    #1;
    rst = 1'b1;
    cfg_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t4_abort");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    #1;
    preload_val = 12'h6C3;
    preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;

    // Fresh load after reset with a stray start pulse mid-shift.
    run_load("t5", 8'h11, 8'h22, 0, 0, 1'b1, 12'h211, 8'hC3, 8'h06, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
